// File: rtl/motoro3_gate_stage.sv
// motoro3_gate_stage
//   Output stage for the motoro3 motor controller. It registers and
//   conditions the motor command on its way to the waveform core, and
//   turns the core's per-phase high/low requests into gate drives that
//   honour a dead-time, block shoot-through, follow a runtime phase-enable
//   mask and shut down on a latched fault.
//
// Ports
//   clk            system clock (10 MHz)
//   nRst           synchronous active-low reset
//   m3start        start command in
//   m3invOrStop    inverse/stop command in
//   m3freq         frequency command in [FREQ_W]
//   m3start_q      registered start to core, held 0 while fltLatched
//   m3invOrStop_q  registered inverse/stop to core
//   m3freq_q       registered frequency, clamped to >= FREQ_MIN [FREQ_W]
//   hReq / lReq    per-phase high/low side requests from core [NPH]
//   phEn           per-phase enable, 0 forces the phase off [NPH]
//   fault          external fault, active-high level
//   fltClr         clears fltLatched and shootErr when fault is low
//   hOut           high-side gate drive, active-high [NPH]
//   lOut           low-side gate drive, active-low when LOW_INV=1 [NPH]
//   fltLatched     sticky fault status
//   shootErr       sticky per-phase simultaneous-request error [NPH]
//
// The per-phase state lives in state_q/cnt_q (unpacked arrays) so that
// checkers can bind to it directly.
module motoro3_gate_stage #(
   parameter int NPH      = 3,
   parameter int FREQ_W   = 10,
   parameter int FREQ_MIN = 1000,
   parameter int DEAD_CYC = 4,
   parameter bit LOW_INV  = 1'b1
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              m3start,
   input  logic              m3invOrStop,
   input  logic [FREQ_W-1:0] m3freq,
   output logic              m3start_q,
   output logic              m3invOrStop_q,
   output logic [FREQ_W-1:0] m3freq_q,
   input  logic [NPH-1:0]    hReq,
   input  logic [NPH-1:0]    lReq,
   input  logic [NPH-1:0]    phEn,
   input  logic              fault,
   input  logic              fltClr,
   output logic [NPH-1:0]    hOut,
   output logic [NPH-1:0]    lOut,
   output logic              fltLatched,
   output logic [NPH-1:0]    shootErr
);

   localparam int                CNT_W   = $clog2(DEAD_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(DEAD_CYC);
   localparam logic [FREQ_W-1:0] FREQ_LO = FREQ_W'(FREQ_MIN);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON_H = 2'd1,
      ST_ON_L = 2'd2
   } phase_state_t;

   phase_state_t     state_q [NPH];
   phase_state_t     state_d [NPH];
   logic [CNT_W-1:0] cnt_q   [NPH];
   logic [CNT_W-1:0] cnt_d   [NPH];

   logic [NPH-1:0] eff_h;
   logic [NPH-1:0] eff_l;
   logic           blocked;
   logic           clr_ok;

   // The raw fault input gates the requests as well as the latched status,
   // so every ON phase drops on the same edge that latches the fault.
   assign blocked = fltLatched | fault;
   assign eff_h   = hReq & ~lReq & phEn & {NPH{~blocked}};
   assign eff_l   = lReq & ~hReq & phEn & {NPH{~blocked}};
   assign clr_ok  = fltClr & ~fault;

   // Next-state logic. Leaving ON always reloads the counter with 1, so the
   // OFF state needs DEAD_CYC-1 further edges before the counter saturates
   // and the next ON can be taken: exactly DEAD_CYC cycles of both-off.
   always_comb begin
      for (int i = 0; i < NPH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_OFF: begin
               if (cnt_q[i] == CNT_SAT) begin
                  if (eff_h[i]) begin
                     state_d[i] = ST_ON_H;
                  end else if (eff_l[i]) begin
                     state_d[i] = ST_ON_L;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            ST_ON_H: begin
               if (!eff_h[i]) begin
                  state_d[i] = ST_OFF;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            ST_ON_L: begin
               if (!eff_l[i]) begin
                  state_d[i] = ST_OFF;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_OFF;
               cnt_d[i]   = CNT_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         for (int i = 0; i < NPH; i++) begin
            state_q[i] <= ST_OFF;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NPH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Command path and sticky status. A new shoot-through on the clear
   // cycle wins over the clear because the set is OR-ed in last.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         m3start_q     <= 1'b0;
         m3invOrStop_q <= 1'b0;
         m3freq_q      <= FREQ_LO;
         fltLatched    <= 1'b0;
         shootErr      <= '0;
      end else begin
         m3start_q     <= m3start & ~fltLatched;
         m3invOrStop_q <= m3invOrStop;
         m3freq_q      <= (m3freq > FREQ_LO) ? m3freq : FREQ_LO;
         fltLatched    <= fault | (fltLatched & ~fltClr);
         shootErr      <= (clr_ok ? '0 : shootErr) | (hReq & lReq);
      end
   end

   // Gate drives decode straight from the state registers.
   always_comb begin
      hOut = '0;
      lOut = {NPH{LOW_INV}};
      for (int i = 0; i < NPH; i++) begin
         hOut[i] = (state_q[i] == ST_ON_H);
         lOut[i] = (state_q[i] == ST_ON_L) ^ LOW_INV;
      end
   end

endmodule

// File: tb/tb_motoro3_gate_stage.sv
`timescale 1ns/1ps
module tb_motoro3_gate_stage;

   localparam int NPH      = 3;
   localparam int FREQ_W   = 10;
   localparam int FREQ_MIN = 1000;
   localparam int DEAD_CYC = 4;
   localparam bit LOW_INV  = 1'b1;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              nRst;
   logic              m3start, m3invOrStop;
   logic [FREQ_W-1:0] m3freq;
   logic              m3start_q, m3invOrStop_q;
   logic [FREQ_W-1:0] m3freq_q;
   logic [NPH-1:0]    hReq, lReq, phEn;
   logic              fault, fltClr;
   logic [NPH-1:0]    hOut, lOut;
   logic              fltLatched;
   logic [NPH-1:0]    shootErr;

   always #50 clk = ~clk;

   motoro3_gate_stage #(
      .NPH(NPH), .FREQ_W(FREQ_W), .FREQ_MIN(FREQ_MIN),
      .DEAD_CYC(DEAD_CYC), .LOW_INV(LOW_INV)
   ) dut (
      .clk(clk), .nRst(nRst),
      .m3start(m3start), .m3invOrStop(m3invOrStop), .m3freq(m3freq),
      .m3start_q(m3start_q), .m3invOrStop_q(m3invOrStop_q), .m3freq_q(m3freq_q),
      .hReq(hReq), .lReq(lReq), .phEn(phEn),
      .fault(fault), .fltClr(fltClr),
      .hOut(hOut), .lOut(lOut),
      .fltLatched(fltLatched), .shootErr(shootErr)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Each phase is described by what it drives (0 none, 1 high, 2 low) and
   // how many edges it has spent with nothing driven (unbounded count).
   int                m_gate [NPH];
   int                m_idle [NPH];
   bit                m_valid = 1'b0;
   bit                m_flt, m_start, m_inv;
   bit [NPH-1:0]      m_shoot;
   int                m_freq;

   always @(posedge clk) begin
      if (!nRst) begin
         m_valid = 1'b1;
         m_flt   = 1'b0;
         m_start = 1'b0;
         m_inv   = 1'b0;
         m_freq  = FREQ_MIN;
         m_shoot = '0;
         for (int i = 0; i < NPH; i++) begin
            m_gate[i] = 0;
            m_idle[i] = 0;
         end
      end else if (m_valid) begin
         for (int i = 0; i < NPH; i++) begin
            int want;
            want = 0;
            if (phEn[i] && !m_flt && !fault && !(hReq[i] && lReq[i])) begin
               if (hReq[i]) want = 1;
               else if (lReq[i]) want = 2;
            end
            if (m_gate[i] != 0) begin
               if (want != m_gate[i]) begin
                  m_gate[i] = 0;
                  m_idle[i] = 1;
               end
            end else if (m_idle[i] >= DEAD_CYC && want != 0) begin
               m_gate[i] = want;
            end else begin
               m_idle[i] = m_idle[i] + 1;
            end
         end
         m_start = m3start && !m_flt;
         m_inv   = m3invOrStop;
         m_freq  = (int'(m3freq) > FREQ_MIN) ? int'(m3freq) : FREQ_MIN;
         if (fltClr && !fault) m_shoot = '0;
         m_shoot = m_shoot | (hReq & lReq);
         if (fault) m_flt = 1'b1;
         else if (fltClr) m_flt = 1'b0;
      end
   end

   // ---------------- compare process ----------------
   logic [NPH-1:0] exp_h, exp_l, overlap;

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < NPH; i++) begin
            exp_h[i]   = (m_gate[i] == 1);
            exp_l[i]   = (m_gate[i] == 2) ^ LOW_INV;
            overlap[i] = hOut[i] && (lOut[i] != LOW_INV);
         end
         chk("hOut",          32'(hOut),          32'(exp_h));
         chk("lOut",          32'(lOut),          32'(exp_l));
         chk("m3start_q",     32'(m3start_q),     32'(m_start));
         chk("m3invOrStop_q", 32'(m3invOrStop_q), 32'(m_inv));
         chk("m3freq_q",      32'(m3freq_q),      32'(m_freq));
         chk("fltLatched",    32'(fltLatched),    32'(m_flt));
         chk("shootErr",      32'(shootErr),      32'(m_shoot));
         chk("no_overlap",    32'(overlap),       0);
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int p;
      nRst = 1'b0; m3start = 1'b0; m3invOrStop = 1'b0; m3freq = '0;
      hReq = '0; lReq = '0; phEn = '1; fault = 1'b0; fltClr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset values
      chk("rst_hOut", 32'(hOut), 0);
      chk("rst_lOut", 32'(lOut), 7);
      chk("rst_freq", 32'(m3freq_q), FREQ_MIN);
      chk("rst_flt",  32'(fltLatched), 0);
      chk("rst_shoot", 32'(shootErr), 0);

      // release with constant high request on phase 0, frequency clamp
      nRst = 1'b1; m3start = 1'b1; m3freq = 10'd500; hReq = 3'b001;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("rise_h0", 32'(hOut[0]), 32'(e == 5));
         chk("idle_l0", 32'(lOut[0]), 1);
         if (e == 1) begin
            chk("freq_clamp", 32'(m3freq_q), 1000);
            chk("start_q", 32'(m3start_q), 1);
            m3freq = 10'd1023;
         end else if (e == 2) begin
            chk("freq_pass", 32'(m3freq_q), 1023);
            m3freq = 10'd1000;
         end else if (e == 3) begin
            chk("freq_eq", 32'(m3freq_q), 1000);
         end
      end

      // phase 0 high -> low with dead-time; phase 1 shoot-through and clear
      hReq = 3'b010; lReq = 3'b001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("sw_h0_off", 32'(hOut[0]), 0);
         chk("sw_l0", 32'(lOut[0]), (k == 5) ? 0 : 1);
         if (k == 1) begin
            chk("h1_on", 32'(hOut[1]), 1);
            lReq[1] = 1'b1;
         end else if (k == 2) begin
            chk("shoot1_set", 32'(shootErr), 2);
            chk("shoot1_off", 32'(hOut[1]), 0);
            lReq[1] = 1'b0; fltClr = 1'b1;
         end else if (k == 3) begin
            chk("shoot1_clr", 32'(shootErr), 0);
            fltClr = 1'b0;
         end
      end

      // bring all phases on, then fault with a clear that must be ignored
      hReq = 3'b110; m3freq = 10'd1020;
      tick(); tick();
      chk("all_on_h", 32'(hOut), 6);
      chk("all_on_l", 32'(lOut), 6);
      fault = 1'b1; fltClr = 1'b1;
      tick();
      chk("flt_set", 32'(fltLatched), 1);
      chk("flt_h_off", 32'(hOut), 0);
      chk("flt_l_off", 32'(lOut), 7);
      chk("flt_start_lag", 32'(m3start_q), 1);
      fault = 1'b0; fltClr = 1'b0;
      tick();
      chk("flt_start_blk", 32'(m3start_q), 0);
      chk("flt_hold", 32'(fltLatched), 1);
      fltClr = 1'b1;
      tick();
      chk("flt_clr", 32'(fltLatched), 0);
      chk("flt_clr_h", 32'(hOut), 0);
      fltClr = 1'b0;
      tick();
      chk("resume_wait", 32'(hOut), 0);
      tick();
      chk("resume_h", 32'(hOut), 6);
      chk("resume_l", 32'(lOut), 6);

      // reset mid-run
      nRst = 1'b0;
      tick();
      chk("mid_rst_h", 32'(hOut), 0);
      chk("mid_rst_l", 32'(lOut), 7);
      chk("mid_rst_freq", 32'(m3freq_q), FREQ_MIN);
      chk("mid_rst_start", 32'(m3start_q), 0);
      nRst = 1'b1;

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NPH; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               r = $urandom_range(0, 9);
               hReq[i] = (r < 4) || (r == 9);
               lReq[i] = (r >= 4 && r < 8) || (r == 9);
            end
         end
         if ($urandom_range(0, 39) == 0) begin
            p = $urandom_range(0, NPH - 1);
            phEn[p] = ~phEn[p];
         end
         fault       = ($urandom_range(0, 149) == 0);
         fltClr      = ($urandom_range(0, 29) == 0);
         m3start     = 1'($urandom_range(0, 1));
         m3invOrStop = 1'($urandom_range(0, 1));
         m3freq      = FREQ_W'($urandom_range(0, 1023));
         nRst        = ($urandom_range(0, 599) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/motoro3_gate_stage.md
Name: motoro3_gate_stage

Overview:
Parametrised successor of the motoro3 top-level output stage. It conditions the motor command (registered start, inverse/stop and clamped frequency) before it reaches the waveform core. It converts the core's per-phase high/low requests into gate drives with:
- enforced dead-time;
- shoot-through protection;
- a runtime phase-enable mask;
- a latched fault shutdown.
Phase count, frequency width/minimum, dead-time and low-side polarity are parameters.

Parameters:
NPH, 3, number of half-bridge phases
FREQ_W, 10, width of frequency command
FREQ_MIN, 1000, lower clamp for frequency command (must fit FREQ_W)
DEAD_CYC, 4, minimum clk cycles both switches of a phase are off between any two ON periods (>=1)
LOW_INV, 1, 1 = low-side gate output active-low (XOR applied), 0 = active-high

Ports:
clk  in  1  system clock (10 MHz)
nRst  in  1  synchronous active-low reset
m3start  in  1  start command
m3invOrStop  in  1  inverse/stop command
m3freq  in  FREQ_W  frequency command
m3start_q  out  1  registered start to core; forced 0 while fltLatched
m3invOrStop_q  out  1  registered inverse/stop to core
m3freq_q  out  FREQ_W  registered, clamped frequency to core
hReq  in  NPH  per-phase high-side request from core
lReq  in  NPH  per-phase low-side request from core
phEn  in  NPH  per-phase enable; 0 forces the phase off
fault  in  1  external fault, active-high, level
fltClr  in  1  fault/error clear pulse
hOut  out  NPH  high-side gate drive, active-high
lOut  out  NPH  low-side gate drive, polarity per LOW_INV
fltLatched  out  1  sticky fault status
shootErr  out  NPH  sticky per-phase simultaneous-request error

Behaviour:
- Reset: all regs update on posedge clk only when nRst=0. Reset values:
  - m3start_q=0, m3invOrStop_q=0, m3freq_q=FREQ_MIN;
  - all phases OFF, offCnt=0;
  - hOut=0; lOut=LOW_INV per bit;
  - fltLatched=0, shootErr=0.
  Reset asserted mid-operation takes effect at the next edge, regardless of state.
- Command path, 1-cycle latency:
  - m3freq_q <= (m3freq > FREQ_MIN) ? m3freq : FREQ_MIN (unsigned compare).
  - m3invOrStop_q <= m3invOrStop.
  - m3start_q <= m3start & ~fltLatched (uses the registered fltLatched value).
- Per-phase FSM, states OFF / ON_H / ON_L, with an offCnt counter of width clog2(DEAD_CYC+1).
  - effH = hReq & ~lReq & phEn & ~fltLatched & ~fault.
  - effL = lReq & ~hReq & phEn & ~fltLatched & ~fault.
  - OFF: offCnt increments, saturating at DEAD_CYC.
    - If offCnt==DEAD_CYC and effH: go to ON_H.
    - Else if offCnt==DEAD_CYC and effL: go to ON_L.
  - ON_H: stays while effH; otherwise go to OFF with offCnt<=1.
  - ON_L: stays while effL; otherwise go to OFF with offCnt<=1.
  - No direct ON_H<->ON_L transition. The gap is exactly DEAD_CYC cycles when the opposite request is already present.
  - After reset release, the earliest ON is DEAD_CYC+1 cycles (offCnt starts at 0).
- Outputs decode directly from the state registers (no extra stage):
  - hOut[i] = (state==ON_H).
  - lOut[i] = (state==ON_L) ^ LOW_INV.
  - Request-to-gate latency is 1 cycle when offCnt is saturated.
- Shoot-through:
  - hReq[i]&lReq[i]=1 sets shootErr[i] (sticky).
  - The phase is treated as no request, so it leaves ON at the next edge.
- Fault:
  - fault=1 sets fltLatched at the next edge.
  - The same edge forces every phase to OFF (offCnt<=1) because fault gates effH/effL directly.
- Clear:
  - fltClr=1 with fault=0 clears fltLatched and all shootErr bits.
  - fltClr while fault=1 is ignored.
  - fltClr coincident with a new shoot-through: set wins.
- phEn[i] falling: phase goes OFF at the next edge. Re-enable still honours dead-time.

Test Plan:
- m3freq=500, then 1023 -> m3freq_q=1000 one cycle later, then 1023; m3freq=1000 -> 1000.
- Reset release, hReq[0]=1 constant, DEAD_CYC=4 -> hOut[0] rises at the 5th edge after release; lOut[0]=1 throughout (LOW_INV=1).
- Phase 0 in ON_H, switch to lReq[0] at edge t -> hOut[0]=0 from t+1; low side active from t+5; never both active.
- hReq[1]=lReq[1]=1 for 1 cycle while ON_H -> shootErr[1]=1 next edge, phase OFF; fltClr -> shootErr=0.
- fault pulse for 1 cycle while all phases ON -> all gates off next edge, fltLatched=1, m3start_q=0.
  - fltClr during fault ignored; fltClr after -> fltLatched=0, gates resume after DEAD_CYC.
- nRst=0 for one cycle mid-run -> all outputs return to reset values at that edge.
